// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types for the serializer transmit path
//
// Purpose: FSM state encoding shared by the serializer and its bench.
// Ports:   none (package).
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } serializer_state_t;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - parameterized loadable down-counter with zero flag
//
// Purpose: bit counter for the serializer; also reusable by receive-side framing.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (has priority over dec)
//   load_val  in   W-bit value to load
//   dec       in   decrement by one this cycle
//   count     out  current count
//   zero      out  count == 0
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-in, LSB-first serial-out transmitter
//
// Purpose: accepts a w-bit word via valid/ready and shifts it out one bit per en tick.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   en          in   bit-rate tick
//   par_in      in   word to transmit (sampled on handshake only)
//   par_valid   in   source has a word on par_in
//   par_ready   out  block accepts par_in this cycle
//   seq_out     out  current serial bit, 0 when idle
//   seq_strobe  out  seq_out is valid and consumed this cycle
//   word_done   out  pulse on the strobe of bit w-1
//   busy        out  a word is in flight
module serializer
  import serializer_pkg::*;
#(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [w-1:0] par_in,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         seq_out,
  output logic         seq_strobe,
  output logic         word_done,
  output logic         busy
);

  localparam int CW = (w > 2) ? $clog2(w) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(w - 1);

  serializer_state_t state, next_state;
  logic [w-1:0]      shreg;
  logic [CW-1:0]     cnt;
  logic              cnt_zero;
  logic              in_shift;
  logic              shift_en;
  logic              last_bit;
  logic              accept;

  assign in_shift = (state == SHIFT);
  assign shift_en = in_shift & en;
  assign last_bit = shift_en & cnt_zero;
  assign accept   = par_valid & par_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (par_valid) next_state = SHIFT;
      SHIFT:   if (last_bit && !par_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    par_ready  = 1'b1;
    seq_out    = 1'b0;
    seq_strobe = 1'b0;
    word_done  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        par_ready = 1'b1;
      end
      SHIFT: begin
        seq_out    = shreg[0];
        seq_strobe = en;
        word_done  = last_bit;
        busy       = 1'b1;
        // Ready only on the last-bit strobe so the next word follows with no gap.
        par_ready  = last_bit;
      end
      default: begin
        par_ready = 1'b1;
      end
    endcase
  end

  // Shift register: a load wins over a shift, which covers the back-to-back case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= par_in;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[w-1:1]};
    end
  end

  // Counter parks at zero after the final bit instead of wrapping.
  bit_counter #(
    .W(CW)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LAST_IDX),
    .dec      (shift_en & ~cnt_zero),
    .count    (cnt),
    .zero     (cnt_zero)
  );

endmodule
